// File: rtl/march_bist_if.sv
// march_bist_if: single-port memory pins driven by the BIST engine.
// master = sequencer (we/addr/wdata out, rdata in); slave = memory.
interface march_bist_if #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8
) ();
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem_rdata;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/march_bist.sv
// march_bist: March C- sequencer over a single-port memory.
// Ports: clk, reset (async high), start, pattern, mem (master),
// busy, done, fail, err_count, first_fail_addr, first_fail_elem.
module march_bist #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8,
  parameter int ERR_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] pattern,
  march_bist_if.master         mem,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [ERR_BITS-1:0]  err_count,
  output logic [ADDR_BITS-1:0] first_fail_addr,
  output logic [2:0]           first_fail_elem
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;
  localparam logic [ERR_BITS-1:0]  ERR_MAX  = '1;
  localparam logic [ERR_BITS-1:0]  ERR_ONE  = 1;

  state_t               state;
  logic [2:0]           elem;
  logic                 op;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] pat;
  logic                 we_q;
  logic [DATA_BITS-1:0] wd_q;

  logic [2:0]           n_elem;
  logic                 n_op;
  logic [ADDR_BITS-1:0] n_addr;
  logic [ADDR_BITS-1:0] term;
  logic                 fin;
  logic                 n_wr;
  logic [DATA_BITS-1:0] n_wd;
  logic [DATA_BITS-1:0] c_exp;
  logic                 mism;

  // M0 and M5 are single-op elements; others are (read, write).
  function automatic logic is_last(input logic [2:0] e, input logic o);
    return (e == 3'd0) || (e == 3'd5) || o;
  endfunction

  function automatic logic is_wr(input logic [2:0] e, input logic o);
    return (e == 3'd0) || ((e != 3'd5) && o);
  endfunction

  // M3/M4 walk the address space downwards.
  function automatic logic is_up(input logic [2:0] e);
    return (e != 3'd3) && (e != 3'd4);
  endfunction

  // Background: 0 = pattern, 1 = ~pattern.
  function automatic logic bg(input logic [2:0] e, input logic o);
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (e == 3'd1), (e == 3'd3): r = o;
      (e == 3'd2), (e == 3'd4): r = ~o;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

  assign term  = is_up(elem) ? ADDR_MAX : '0;
  assign c_exp = bg(elem, op) ? ~pat : pat;
  assign mism  = !is_wr(elem, op) && (mem.mem_rdata != c_exp);

  always_comb begin
    n_elem = elem;
    n_op   = 1'b0;
    n_addr = addr;
    fin    = 1'b0;
    if (!is_last(elem, op)) begin
      n_op = 1'b1;
    end else if (addr != term) begin
      n_addr = is_up(elem) ? addr + ADDR_ONE : addr - ADDR_ONE;
    end else if (elem == 3'd5) begin
      fin = 1'b1;
    end else begin
      n_elem = elem + 3'd1;
      n_addr = is_up(n_elem) ? '0 : ADDR_MAX;
    end
  end

  assign n_wr = is_wr(n_elem, n_op);
  assign n_wd = !n_wr ? '0 :
                bg(n_elem, n_op) ? ~pat : pat;

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      elem            <= '0;
      op              <= 1'b0;
      addr            <= '0;
      pat             <= '0;
      we_q            <= 1'b0;
      wd_q            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      fail            <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
      first_fail_elem <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RUN;
            pat             <= pattern;
            elem            <= '0;
            op              <= 1'b0;
            addr            <= '0;
            we_q            <= 1'b1;
            wd_q            <= pattern;
            busy            <= 1'b1;
            done            <= 1'b0;
            fail            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            first_fail_elem <= '0;
          end
        end
        RUN: begin
          if (mism) begin
            if (err_count != ERR_MAX)
              err_count <= err_count + ERR_ONE;
            if (!fail) begin
              fail            <= 1'b1;
              first_fail_addr <= addr;
              first_fail_elem <= elem;
            end
          end
          if (fin) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            elem  <= '0;
            op    <= 1'b0;
            addr  <= '0;
            we_q  <= 1'b0;
            wd_q  <= '0;
          end else begin
            elem <= n_elem;
            op   <= n_op;
            addr <= n_addr;
            we_q <= n_wr;
            wd_q <= n_wd;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_march_bist.sv
// tb_march_bist: March C- BIST bench with faulty-memory models
// and a notation-level reference of the march sequence.
module tb_march_bist;

  localparam int N   = 16;
  localparam int RL  = 10 * N;
  localparam int LIM = RL + 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pattern;

  always #5 clk = ~clk;

  march_bist_if #(.ADDR_BITS(4), .DATA_BITS(8)) bus_a ();
  march_bist_if #(.ADDR_BITS(4), .DATA_BITS(8)) bus_b ();

  logic       busy_a, done_a, fail_a;
  logic [7:0] err_a;
  logic [3:0] ffa_a;
  logic [2:0] ffe_a;
  logic       busy_b, done_b, fail_b;
  logic [1:0] err_b;
  logic [3:0] ffa_b;
  logic [2:0] ffe_b;

  march_bist #(.ADDR_BITS(4), .DATA_BITS(8), .ERR_BITS(8)) dut_a (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .mem(bus_a), .busy(busy_a), .done(done_a), .fail(fail_a),
    .err_count(err_a), .first_fail_addr(ffa_a),
    .first_fail_elem(ffe_a)
  );

  march_bist #(.ADDR_BITS(4), .DATA_BITS(8), .ERR_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .mem(bus_b), .busy(busy_b), .done(done_b), .fail(fail_b),
    .err_count(err_b), .first_fail_addr(ffa_b),
    .first_fail_elem(ffe_b)
  );

  // Memories with per-address stuck-at-0 / stuck-at-1 masks.
  logic [7:0] mem_a [N];
  logic [7:0] mem_b [N];
  logic [7:0] s0_a [N];
  logic [7:0] s1_a [N];
  logic [7:0] s0_b [N];
  logic [7:0] s1_b [N];

  always @(posedge clk) if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
  always @(posedge clk) if (bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;

  assign bus_a.mem_rdata = (mem_a[bus_a.mem_addr] & ~s0_a[bus_a.mem_addr])
                         | s1_a[bus_a.mem_addr];
  assign bus_b.mem_rdata = (mem_b[bus_b.mem_addr] & ~s0_b[bus_b.mem_addr])
                         | s1_b[bus_b.mem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle bus activity.
  bit         exp_we [$];
  logic [3:0] exp_ad [$];
  logic [7:0] exp_wd [$];

  // Observed trace.
  logic       tr_we [LIM];
  logic [3:0] tr_ad [LIM];
  logic [7:0] tr_wd [LIM];
  int         obs_len;

  // Model results: a = 8-bit counter, b = 2-bit counter.
  int me_a, mf_a, ma_a, mel_a;
  int me_b, mf_b, ma_b, mel_b;

  // March C- in notation form: op codes 0=r0 1=r1 2=w0 3=w1 -1=none.
  int mk [6][2] = '{'{2, -1}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, -1}};
  bit mup [6]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      s0_a[i] = 8'h00; s1_a[i] = 8'h00;
      s0_b[i] = 8'h00; s1_b[i] = 8'h00;
    end
  endtask

  task automatic model_one(input logic [7:0] p, input bit selb, input int emax,
                           output int errs, output int fl, output int fa,
                           output int fe);
    logic [7:0] mm [N];
    logic [7:0] v, rd, s0, s1;
    int a, k;
    errs = 0; fl = 0; fa = 0; fe = 0;
    for (int i = 0; i < N; i++) mm[i] = 8'h00;
    if (!selb) begin
      exp_we.delete(); exp_ad.delete(); exp_wd.delete();
    end
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = mup[e] ? i : N - 1 - i;
        for (int j = 0; j < 2; j++) begin
          k = mk[e][j];
          if (k < 0) continue;
          v = (k % 2 == 1) ? ~p : p;
          if (k >= 2) begin
            mm[a] = v;
            if (!selb) begin
              exp_we.push_back(1'b1); exp_ad.push_back(4'(a)); exp_wd.push_back(v);
            end
          end else begin
            if (!selb) begin
              exp_we.push_back(1'b0); exp_ad.push_back(4'(a)); exp_wd.push_back(8'h00);
            end
            s0 = selb ? s0_b[a] : s0_a[a];
            s1 = selb ? s1_b[a] : s1_a[a];
            rd = (mm[a] & ~s0) | s1;
            if (rd !== v) begin
              if (errs < emax) errs++;
              if (fl == 0) begin fl = 1; fa = a; fe = e; end
            end
          end
        end
      end
    end
  endtask

  task automatic model_run(input logic [7:0] p);
    model_one(p, 1'b0, 255, me_a, mf_a, ma_a, mel_a);
    model_one(p, 1'b1, 3, me_b, mf_b, ma_b, mel_b);
  endtask

  task automatic do_run(input logic [7:0] p, input int chg_cyc,
                        input logic [7:0] chg_pat, input int pulse_cyc);
    int k;
    @(negedge clk);
    pattern = p;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (busy_a === 1'b1 && k < LIM) begin
      tr_we[k] = bus_a.mem_we;
      tr_ad[k] = bus_a.mem_addr;
      tr_wd[k] = bus_a.mem_wdata;
      if (k == chg_cyc) pattern = chg_pat;
      if (k == pulse_cyc) start = 1'b1;
      if (k == pulse_cyc + 1) start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    obs_len = k;
  endtask

  function automatic int trace_errs();
    int m = 0;
    if (obs_len != exp_we.size()) m++;
    for (int i = 0; i < obs_len && i < exp_we.size(); i++)
      if (tr_we[i] !== exp_we[i] || tr_ad[i] !== exp_ad[i] || tr_wd[i] !== exp_wd[i])
        m++;
    return m;
  endfunction

  function automatic int we_count();
    int c = 0;
    for (int i = 0; i < obs_len; i++) if (tr_we[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset();
    logic [26:0] o;
    reset = 1'b1; start = 1'b0; pattern = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    o = {busy_a, done_a, fail_a, err_a, ffa_a, ffe_a,
         bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata[4:0]};
    n_checks++;
    if (o !== '0) begin
      n_fail++; $display("FAIL reset_outs: got %h want 0", o);
    end
    n_checks++;
    if (bus_a.mem_wdata !== 8'h00 || err_b !== 2'b00) begin
      n_fail++; $display("FAIL reset_wdata: got %h/%h want 0", bus_a.mem_wdata, err_b);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_fault_free();
    clear_faults();
    model_run(8'h00);
    do_run(8'h00, -1, 8'h00, -1);
    n_checks++;
    if (obs_len !== RL) begin
      n_fail++; $display("FAIL ff_busy_len: got %0d want %0d", obs_len, RL);
    end
    n_checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL ff_done: got done=%b busy=%b want 1/0", done_a, busy_a);
    end
    n_checks++;
    if (fail_a !== 1'b0 || int'(err_a) !== me_a) begin
      n_fail++; $display("FAIL ff_err: got fail=%b err=%0d want 0/%0d", fail_a, err_a, me_a);
    end
    n_checks++;
    if (we_count() !== 5 * N) begin
      n_fail++; $display("FAIL ff_we_count: got %0d want %0d", we_count(), 5 * N);
    end
    n_checks++;
    if (tr_ad[80] !== 4'd15 || tr_ad[144] !== 4'd0) begin
      n_fail++; $display("FAIL ff_addr_pts: got %0d/%0d want 15/0", tr_ad[80], tr_ad[144]);
    end
    n_checks++;
    if (trace_errs() !== 0) begin
      n_fail++; $display("FAIL ff_trace: got %0d bad cycles want 0", trace_errs());
    end
  endtask

  task automatic test_stuck_bit();
    clear_faults();
    s1_a[5] = 8'h01;
    model_run(8'h00);
    do_run(8'h00, -1, 8'h00, -1);
    n_checks++;
    if (fail_a !== 1'b1 || int'(err_a) !== me_a || me_a != 3) begin
      n_fail++; $display("FAIL sb_err: got fail=%b err=%0d want 1/3", fail_a, err_a);
    end
    n_checks++;
    if (ffa_a !== 4'd5 || ffe_a !== 3'd1) begin
      n_fail++; $display("FAIL sb_first: got addr=%0d elem=%0d want 5/1", ffa_a, ffe_a);
    end
    n_checks++;
    if (done_a !== 1'b1 || obs_len !== RL) begin
      n_fail++; $display("FAIL sb_done: got done=%b len=%0d want 1/%0d", done_a, obs_len, RL);
    end
  endtask

  task automatic test_pattern();
    clear_faults();
    model_run(8'hA5);
    do_run(8'hA5, 30, 8'($urandom), -1);
    n_checks++;
    if (tr_wd[0] !== 8'hA5 || tr_wd[N + 1] !== 8'h5A) begin
      n_fail++; $display("FAIL pat_wdata: got %h/%h want a5/5a", tr_wd[0], tr_wd[N + 1]);
    end
    n_checks++;
    if (trace_errs() !== 0) begin
      n_fail++; $display("FAIL pat_trace: got %0d bad cycles want 0", trace_errs());
    end
    n_checks++;
    if (fail_a !== 1'b0 || err_a !== 8'd0) begin
      n_fail++; $display("FAIL pat_err: got fail=%b err=%0d want 0/0", fail_a, err_a);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    clear_faults();
    s1_a[5] = 8'h01;
    model_run(8'h00);
    do_run(8'h00, -1, 8'h00, 40);
    n_checks++;
    if (obs_len !== RL || done_a !== 1'b1 || int'(err_a) !== me_a) begin
      n_fail++;
      $display("FAIL b2b_ignore: got len=%0d done=%b err=%0d want %0d/1/%0d",
               obs_len, done_a, err_a, RL, me_a);
    end
    start = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy_a !== 1'b1 || done_a !== 1'b0 || err_a !== 8'd0 || fail_a !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart: got busy=%b done=%b err=%0d fail=%b want 1/0/0/0",
               busy_a, done_a, err_a, fail_a);
    end
    start = 1'b0;
    k = 0;
    while (busy_a === 1'b1 && k < LIM) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (k !== RL || done_a !== 1'b1 || int'(err_a) !== me_a) begin
      n_fail++;
      $display("FAIL b2b_second: got len=%0d done=%b err=%0d want %0d/1/%0d",
               k, done_a, err_a, RL, me_a);
    end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] p;
    logic [26:0] o;
    bit saw_done;
    clear_faults();
    s1_a[2] = 8'h01;
    @(negedge clk);
    pattern = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) begin @(posedge clk); #1; end
    n_checks++;
    if (fail_a !== 1'b1 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL rst_prefail: got fail=%b busy=%b want 1/1", fail_a, busy_a);
    end
    reset = 1'b1;
    #1;
    o = {busy_a, done_a, fail_a, err_a, ffa_a, ffe_a,
         bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata[4:0]};
    n_checks++;
    if (o !== '0 || bus_a.mem_wdata !== 8'h00) begin
      n_fail++; $display("FAIL rst_async: got %h/%h want 0", o, bus_a.mem_wdata);
    end
    saw_done = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (done_a) saw_done = 1'b1; end
    @(negedge clk); reset = 1'b0;
    repeat (RL) begin @(posedge clk); #1; if (done_a || busy_a) saw_done = 1'b1; end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_nodone: got activity=%b want 0", saw_done);
    end
    clear_faults();
    p = 8'($urandom);
    model_run(p);
    do_run(p, -1, 8'h00, -1);
    n_checks++;
    if (obs_len !== RL || done_a !== 1'b1 || err_a !== 8'd0 || trace_errs() !== 0) begin
      n_fail++;
      $display("FAIL rst_rerun: got len=%0d done=%b err=%0d bad=%0d want %0d/1/0/0",
               obs_len, done_a, err_a, trace_errs(), RL);
    end
  endtask

  task automatic test_saturation();
    clear_faults();
    s0_b[3] = 8'hFF;
    s0_b[9] = 8'hFF;
    model_run(8'h00);
    do_run(8'h00, -1, 8'h00, -1);
    n_checks++;
    if (int'(err_b) !== me_b || me_b != 3 || fail_b !== 1'b1) begin
      n_fail++; $display("FAIL sat_err: got err=%0d fail=%b want 3/1", err_b, fail_b);
    end
    n_checks++;
    if (ffa_b !== 4'd3 || ffe_b !== 3'd2) begin
      n_fail++; $display("FAIL sat_first: got addr=%0d elem=%0d want 3/2", ffa_b, ffe_b);
    end
    n_checks++;
    if (err_a !== 8'd0 || done_b !== 1'b1) begin
      n_fail++; $display("FAIL sat_other: got err_a=%0d done_b=%b want 0/1", err_a, done_b);
    end
  endtask

  task automatic test_random();
    logic [7:0] p;
    int a;
    for (int it = 0; it < 4; it++) begin
      clear_faults();
      p = 8'($urandom);
      a = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 1) s1_a[a] = 8'($urandom_range(1, 255));
      else s0_a[a] = 8'($urandom_range(1, 255));
      model_run(p);
      do_run(p, -1, 8'h00, -1);
      n_checks++;
      if (int'(err_a) !== me_a || int'(fail_a) !== mf_a ||
          int'(ffa_a) !== ma_a || int'(ffe_a) !== mel_a) begin
        n_fail++;
        $display("FAIL rnd_%0d: got err=%0d fail=%b a=%0d e=%0d want %0d/%0d/%0d/%0d",
                 it, err_a, fail_a, ffa_a, ffe_a, me_a, mf_a, ma_a, mel_a);
      end
      n_checks++;
      if (trace_errs() !== 0 || done_a !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd_trace_%0d: got bad=%0d done=%b want 0/1", it, trace_errs(), done_a);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pattern = 8'h00;
    clear_faults();
    for (int i = 0; i < N; i++) begin mem_a[i] = 8'h00; mem_b[i] = 8'h00; end
    test_reset();
    test_fault_free();
    test_stuck_bit();
    test_pattern();
    test_back_to_back();
    test_reset_midrun();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
